// File: rtl/xor_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// xor_arbiter_pkg : shared state encodings, operand width and LAT limits
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package xor_arbiter_pkg;

   localparam int C_OP_W    = 4;
   localparam int C_LAT_MIN = 1;
   localparam int C_LAT_MAX = 15;
   localparam int C_CNT_W   = 4;
   localparam int C_OPC_W   = 8;

   typedef logic [C_OP_W-1:0] operand_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/xor_arbiter_if.sv
// ---------------------------------------------------------------------------
// xor_arbiter_if : request/grant/done bundle between requesters and arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface xor_arbiter_if;
   import xor_arbiter_pkg::*;

   logic                 req0;
   logic                 req1;
   operand_t             a0;
   operand_t             b0;
   operand_t             a1;
   operand_t             b1;
   logic                 gnt0;
   logic                 gnt1;
   logic                 done0;
   logic                 done1;
   operand_t             z_out;
   logic                 done_id;
   logic                 busy;
   logic [C_OPC_W-1:0]   op_count;

   modport master (
      output req0, req1, a0, b0, a1, b1,
      input  gnt0, gnt1, done0, done1, z_out, done_id, busy, op_count
   );

   modport slave (
      input  req0, req1, a0, b0, a1, b1,
      output gnt0, gnt1, done0, done1, z_out, done_id, busy, op_count
   );

endinterface

`default_nettype wire

// File: rtl/ModuloXor.sv
// ---------------------------------------------------------------------------
// ModuloXor : bitwise modulo-2 sum of two operands
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ModuloXor
   import xor_arbiter_pkg::*;
(
   input  operand_t a,
   input  operand_t b,
   output operand_t z
);

   assign z = a ^ b;

endmodule

`default_nettype wire

// File: rtl/xor_arbiter.sv
// ---------------------------------------------------------------------------
// xor_arbiter : round-robin sharing of one ModuloXor between two requesters
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module xor_arbiter
   import xor_arbiter_pkg::*;
#(
   parameter int LAT = 1
)
(
   input  logic         clk,
   input  logic         rst,
   xor_arbiter_if.slave bus
);

   localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'(LAT - 1);

   state_t               state_q,    state_d;
   logic [C_CNT_W-1:0]   cnt_q,      cnt_d;
   operand_t             op_a_q,     op_a_d;
   operand_t             op_b_q,     op_b_d;
   logic                 sel_q,      sel_d;
   logic                 last_gnt_q, last_gnt_d;
   operand_t             z_out_q,    z_out_d;
   logic                 done_id_q,  done_id_d;
   logic [C_OPC_W-1:0]   op_count_q, op_count_d;

   logic                 w_winner;
   operand_t             w_xor_z;

   // The shared unit only ever sees the latched operands.
   ModuloXor u_modulo_xor (
      .a (op_a_q),
      .b (op_b_q),
      .z (w_xor_z)
   );

   // On a tie the side that did not win last time takes the grant.
   assign w_winner = (bus.req0 && bus.req1) ? ~last_gnt_q : bus.req1;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      sel_d      = sel_q;
      last_gnt_d = last_gnt_q;
      z_out_d    = z_out_q;
      done_id_d  = done_id_q;
      op_count_d = op_count_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.req0 || bus.req1) begin
               state_d    = ST_BUSY;
               op_a_d     = w_winner ? bus.a1 : bus.a0;
               op_b_d     = w_winner ? bus.b1 : bus.b0;
               sel_d      = w_winner;
               last_gnt_d = w_winner;
               cnt_d      = C_CNT_LOAD;
            end
         end
         ST_BUSY: begin
            if (cnt_q == '0) begin
               state_d    = ST_DONE;
               z_out_d    = w_xor_z;
               done_id_d  = sel_q;
               op_count_d = op_count_q + 8'd1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         sel_q      <= 1'b0;
         last_gnt_q <= 1'b1;
         z_out_q    <= '0;
         done_id_q  <= 1'b0;
         op_count_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         sel_q      <= sel_d;
         last_gnt_q <= last_gnt_d;
         z_out_q    <= z_out_d;
         done_id_q  <= done_id_d;
         op_count_q <= op_count_d;
      end
   end

   assign bus.gnt0     = (state_q == ST_BUSY) && !sel_q;
   assign bus.gnt1     = (state_q == ST_BUSY) &&  sel_q;
   assign bus.done0    = (state_q == ST_DONE) && !done_id_q;
   assign bus.done1    = (state_q == ST_DONE) &&  done_id_q;
   assign bus.busy     = (state_q != ST_IDLE);
   assign bus.z_out    = z_out_q;
   assign bus.done_id  = done_id_q;
   assign bus.op_count = op_count_q;

endmodule

`default_nettype wire

// File: tb/tb_xor_arbiter.sv
// ---------------------------------------------------------------------------
// tb_xor_arbiter : directed checks of xor_arbiter at LAT = 1, 3 and 4
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_xor_arbiter;
   import xor_arbiter_pkg::*;

   localparam int L1 = 1;
   localparam int L3 = 3;
   localparam int L4 = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   xor_arbiter_if if1 ();
   xor_arbiter_if if3 ();
   xor_arbiter_if if4 ();

   xor_arbiter #(.LAT(L1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   xor_arbiter #(.LAT(L3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));
   xor_arbiter #(.LAT(L4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if1.req0 = 0; if1.req1 = 0; if1.a0 = 0; if1.b0 = 0; if1.a1 = 0; if1.b1 = 0;
      if3.req0 = 0; if3.req1 = 0; if3.a0 = 0; if3.b0 = 0; if3.a1 = 0; if3.b1 = 0;
      if4.req0 = 0; if4.req1 = 0; if4.a0 = 0; if4.b0 = 0; if4.a1 = 0; if4.b1 = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [17:0] v;
      idle_inputs();
      rst = 1'b1;
      if1.req0 = 1; if1.req1 = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         v = {if1.gnt0, if1.gnt1, if1.done0, if1.done1, if1.busy, if1.done_id,
              if1.z_out, if1.op_count};
         checks++;
         if (v !== 18'h0) begin
            errors++;
            $display("FAIL reset_outputs cycle %0d got %h expected 0", i, v);
         end
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({if1.gnt0, if1.gnt1} !== 2'b10) begin
         errors++;
         $display("FAIL reset_first_grant got gnt0/gnt1=%b expected 10", {if1.gnt0, if1.gnt1});
      end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      if1.req0 = 1; if1.a0 = 4'hA; if1.b0 = 4'h5;
      tick();
      checks++;
      if ({if1.gnt0, if1.gnt1, if1.busy, if1.done0} !== 4'b1010) begin
         errors++;
         $display("FAIL single_grant got gnt0,gnt1,busy,done0=%b expected 1010",
                  {if1.gnt0, if1.gnt1, if1.busy, if1.done0});
      end
      if1.req0 = 0;
      tick();
      checks++;
      if ({if1.done0, if1.done1, if1.gnt0, if1.done_id, if1.z_out, if1.op_count} !==
          {1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 8'd1}) begin
         errors++;
         $display("FAIL single_done got done0=%b done1=%b gnt0=%b id=%b z=%h cnt=%0d expected 1 0 0 0 f 1",
                  if1.done0, if1.done1, if1.gnt0, if1.done_id, if1.z_out, if1.op_count);
      end
      tick();
      checks++;
      if ({if1.done0, if1.busy, if1.z_out} !== {1'b0, 1'b0, 4'hF}) begin
         errors++;
         $display("FAIL single_idle_hold got done0=%b busy=%b z=%h expected 0 0 f",
                  if1.done0, if1.busy, if1.z_out);
      end
   endtask

   task automatic test_contention();
      int       n;
      logic     eid;
      operand_t ez;
      do_reset();
      if3.req0 = 1; if3.a0 = 4'h3; if3.b0 = 4'h3;
      if3.req1 = 1; if3.a1 = 4'hC; if3.b1 = 4'h1;
      n = 0;
      for (int c = 1; c <= 30 && n < 4; c++) begin
         tick();
         if (if3.done0 || if3.done1) begin
            eid = n[0];
            ez  = eid ? 4'hD : 4'h0;
            checks++;
            if ({if3.done0, if3.done1, if3.done_id, if3.z_out} !== {~eid, eid, eid, ez} ||
                c != 4 + 5 * n) begin
               errors++;
               $display("FAIL contention_done%0d got cycle=%0d d0=%b d1=%b id=%b z=%h expected cycle=%0d id=%b z=%h",
                        n, c, if3.done0, if3.done1, if3.done_id, if3.z_out, 4 + 5 * n, eid, ez);
            end
            n++;
         end
      end
      if (n < 4) begin
         checks++;
         errors++;
         $display("FAIL contention_timeout got %0d done pulses expected 4", n);
      end
      if3.req0 = 0; if3.req1 = 0;
   endtask

   task automatic test_operand_change();
      int w;
      do_reset();
      if4.req0 = 1; if4.a0 = 4'h6; if4.b0 = 4'h2;
      tick();
      checks++;
      if (if4.gnt0 !== 1'b1) begin
         errors++;
         $display("FAIL opchg_grant got gnt0=%b expected 1", if4.gnt0);
      end
      if4.a0 = 4'hF; if4.req0 = 0;
      w = 0;
      while (w < 10 && if4.done0 !== 1'b1) begin
         tick();
         w++;
      end
      checks++;
      if (w != 4 || if4.z_out !== 4'h4 || if4.done_id !== 1'b0) begin
         errors++;
         $display("FAIL opchg_result got wait=%0d z=%h id=%b expected wait=4 z=4 id=0",
                  w, if4.z_out, if4.done_id);
      end
   endtask

   task automatic test_reset_mid_busy();
      int w;
      do_reset();
      if4.req0 = 1; if4.a0 = 4'h1; if4.b0 = 4'h2;
      if4.req1 = 1; if4.a1 = 4'h4; if4.b1 = 4'h8;
      tick();
      checks++;
      if ({if4.gnt0, if4.gnt1} !== 2'b10) begin
         errors++;
         $display("FAIL midrst_first_grant got %b expected 10", {if4.gnt0, if4.gnt1});
      end
      tick();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({if4.busy, if4.gnt0, if4.gnt1, if4.done0, if4.done1, if4.op_count} !== 13'h0) begin
            errors++;
            $display("FAIL midrst_discard cycle %0d got busy=%b gnt=%b%b done=%b%b cnt=%0d expected all 0",
                     i, if4.busy, if4.gnt0, if4.gnt1, if4.done0, if4.done1, if4.op_count);
         end
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({if4.gnt0, if4.gnt1, if4.op_count} !== {2'b10, 8'd0}) begin
         errors++;
         $display("FAIL midrst_tie_after got gnt=%b%b cnt=%0d expected 10 0",
                  if4.gnt0, if4.gnt1, if4.op_count);
      end
      if4.req0 = 0; if4.req1 = 0;
      w = 0;
      while (w < 10 && if4.done0 !== 1'b1) begin
         tick();
         w++;
      end
      checks++;
      if (w != 4 || if4.op_count !== 8'd1 || if4.z_out !== 4'h3) begin
         errors++;
         $display("FAIL midrst_complete got wait=%0d cnt=%0d z=%h expected wait=4 cnt=1 z=3",
                  w, if4.op_count, if4.z_out);
      end
   endtask

   task automatic test_exhaustive();
      logic [7:0] iv;
      logic       r;
      operand_t   a, b;
      do_reset();
      for (int i = 0; i < 256; i++) begin
         iv = 8'(i);
         r  = iv[0];
         a  = iv[7:4];
         b  = iv[3:0];
         if (r) begin
            if1.req1 = 1; if1.a1 = a; if1.b1 = b; if1.a0 = ~a; if1.b0 = 4'h0;
         end else begin
            if1.req0 = 1; if1.a0 = a; if1.b0 = b; if1.a1 = ~a; if1.b1 = 4'h0;
         end
         tick();
         checks++;
         if ({if1.gnt0, if1.gnt1} !== {~r, r}) begin
            errors++;
            $display("FAIL exh_grant op %0d got %b%b expected %b%b", i, if1.gnt0, if1.gnt1, ~r, r);
         end
         if1.req0 = 0; if1.req1 = 0;
         if1.a0 = 4'h9; if1.b0 = 4'h6; if1.a1 = 4'h6; if1.b1 = 4'h9;
         tick();
         checks++;
         if ({if1.done0, if1.done1, if1.done_id, if1.z_out, if1.op_count} !==
             {~r, r, r, a ^ b, 8'(i + 1)}) begin
            errors++;
            $display("FAIL exh_result op %0d got d=%b%b id=%b z=%h cnt=%0d expected id=%b z=%h cnt=%0d",
                     i, if1.done0, if1.done1, if1.done_id, if1.z_out, if1.op_count,
                     r, a ^ b, 8'(i + 1));
            $fatal(1, "exhaustive check stopped at op %0d", i);
         end
         tick();
      end
      checks++;
      if (if1.op_count !== 8'd0) begin
         errors++;
         $display("FAIL exh_wrap got op_count=%0d expected 0", if1.op_count);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      if (L1 < C_LAT_MIN || L1 > C_LAT_MAX || L3 < C_LAT_MIN || L3 > C_LAT_MAX ||
          L4 < C_LAT_MIN || L4 > C_LAT_MAX) begin
         $display("FAIL lat_range bench LAT values outside %0d..%0d", C_LAT_MIN, C_LAT_MAX);
         $fatal(1, "illegal LAT");
      end
      test_reset();
      test_single();
      test_contention();
      test_operand_change();
      test_reset_mid_busy();
      test_exhaustive();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
